// File: rtl/mp3_track_feeder.sv
// mp3_track_feeder: streams fixed-length MP3 tracks from block ROM
// through a small prefetch FIFO onto a valid/ready word stream.
// Ports: clk, RST (async, active-low); play, next_pulse, prev_pulse
// controls; mem_en/mem_addr/mem_dout ROM port (data 1 cycle after
// mem_en); word_data/word_valid/word_ready output stream;
// track/playing/track_end status.
// Option: define MP3_AUTO_NEXT_EN for gapless advance to the next
// track; otherwise the block parks at end of track.

module mp3_track_feeder #(
    parameter int ADDR_W     = 12,
    parameter int TRACK_NUM  = 4,
    parameter int TRK_W      = 2,
    parameter int TRACK_LEN  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              play,
    input  logic              next_pulse,
    input  logic              prev_pulse,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_dout,
    output logic [15:0]       word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [TRK_W-1:0]  track,
    output logic              playing,
    output logic              track_end
);

    localparam int PW = $clog2(TRACK_LEN) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    logic [1:0]       r_state;
    logic [TRK_W-1:0] r_track;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_inflight;
    logic [15:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_skip;
    logic             w_issue;
    logic             w_empty;
    logic             w_wr;
    logic             w_pop;
    logic             w_done;
    logic             w_last;
    logic [CW-1:0]    w_occ;
    logic [TRK_W-1:0] w_trk_inc;
    logic [TRK_W-1:0] w_trk_dec;

    assign w_skip  = next_pulse | prev_pulse;
    assign w_empty = (r_count == '0);
    assign w_last  = (r_rd_ptr == PW'(TRACK_LEN - 1));

    // Words already in the FIFO plus the one on its way back from ROM;
    // issuing only below depth guarantees every return has a slot.
    assign w_occ   = r_count + CW'(r_inflight);

    // No issue during a skip: the address counter is being retargeted.
    assign w_issue = (r_state == S_FETCH) && play && !w_skip
                     && (w_occ < CW'(FIFO_DEPTH));

    // A return landing in a skip cycle belongs to the old track.
    assign w_wr    = r_inflight && !w_skip;
    assign w_pop   = word_valid && word_ready;
    assign w_done  = (r_state == S_DRAIN) && w_empty
                     && !r_inflight && !w_skip;

    assign w_trk_inc = (r_track == TRK_W'(TRACK_NUM - 1)) ?
                       '0 : r_track + TRK_W'(1);
    assign w_trk_dec = (r_track == '0) ?
                       TRK_W'(TRACK_NUM - 1) : r_track - TRK_W'(1);

    assign mem_en     = w_issue;
    assign mem_addr   = ADDR_W'(r_track) * ADDR_W'(TRACK_LEN)
                        + ADDR_W'(r_rd_ptr);
    assign word_data  = r_mem[r_rptr];
    assign word_valid = !w_empty && play;
    assign track      = r_track;
    assign playing    = play && ((r_state == S_FETCH)
                                 || (r_state == S_DRAIN));
    assign track_end  = w_done;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_track    <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (next_pulse) begin
                r_track  <= w_trk_inc;
                r_rd_ptr <= '0;
                r_state  <= S_FETCH;
            end else if (prev_pulse) begin
                r_track  <= w_trk_dec;
                r_rd_ptr <= '0;
                r_state  <= S_FETCH;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (play) r_state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (w_issue && w_last) r_state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (w_done) r_state <= S_END;
                    end
                    S_END: begin
`ifdef MP3_AUTO_NEXT_EN
                        r_track  <= w_trk_inc;
                        r_rd_ptr <= '0;
                        r_state  <= S_FETCH;
`else
                        if (!play) begin
                            r_state  <= S_IDLE;
                            r_rd_ptr <= '0;
                        end
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_mem   <= '{default: '0};
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_skip) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= mem_dout;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mp3_track_feeder.sv
// Testbench for mp3_track_feeder: vector table, corner sequences and
// randomized traffic against a word-order / track scoreboard.

module tb_mp3_track_feeder;

    localparam int TL = 1024;
    localparam int NT = 4;
    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        RST;
    logic        play;
    logic        next_pulse;
    logic        prev_pulse;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [15:0] mem_dout = 16'h0;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [1:0]  track;
    logic        playing;
    logic        track_end;

    int n_chk = 0;
    int n_err = 0;

    int m_track, m_iss, m_pop, m_occ, n_end, n_pop;
    bit m_ended, m_pend;
    bit mp, ms;
    int base;

    always #5 clk = ~clk;

    mp3_track_feeder dut (
        .clk        (clk),
        .RST        (RST),
        .play       (play),
        .next_pulse (next_pulse),
        .prev_pulse (prev_pulse),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .track      (track),
        .playing    (playing),
        .track_end  (track_end)
    );

    // ROM content equals its own address.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= 16'(mem_addr);
    end

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: words must leave as track*TL + 0,1,2,...; ROM reads
    // must be consecutive from the track base and never exceed the
    // track; buffered + outstanding words never exceed 4.
    always @(negedge clk) begin
        if (RST !== 1'b1) begin
            m_track = 0; m_iss = 0; m_pop = 0; m_occ = 0;
            n_end = 0; m_ended = 0; m_pend = 0;
        end else begin
            base = m_track * TL;
            mp = word_valid && word_ready;
            ms = next_pulse || prev_pulse;
            chk(int'(track) == m_track, "track", track, m_track);
            chk(!word_valid || play, "valid_while_paused",
                word_valid, 0);
            if (mem_en) begin
                chk(int'(mem_addr) == base + m_iss && m_iss < TL,
                    "issue_addr", mem_addr, base + m_iss);
                chk(m_occ < 4, "fifo_room", m_occ, 3);
            end
            if (mp) begin
                chk(int'(word_data) == base + m_pop, "word_order",
                    word_data, base + m_pop);
                n_pop++;
            end
            if (track_end) begin
                n_end++;
                chk(m_pop == TL && m_occ == 0, "end_count", m_pop, TL);
            end
            if (m_ended) begin
                chk(!word_valid && !playing && !mem_en, "end_hold",
                    {word_valid, playing, mem_en}, 0);
            end
            if (ms) begin
                m_track = next_pulse ? (m_track + 1) % NT
                                     : (m_track + NT - 1) % NT;
                m_iss = 0; m_pop = 0; m_occ = 0;
                m_ended = 0; m_pend = 0;
            end else begin
                if (mem_en) m_iss++;
                if (mp) m_pop++;
                m_occ += int'(mem_en) - int'(mp);
                if (m_pend) begin
                    m_track = (m_track + 1) % NT;
                    m_iss = 0; m_pop = 0; m_pend = 0;
                end else if (m_ended && !play) begin
                    m_ended = 0; m_iss = 0; m_pop = 0;
                end
                if (track_end) begin
`ifdef MP3_AUTO_NEXT_EN
                    m_pend = 1;
`else
                    m_ended = 1;
`endif
                end
            end
        end
    end

    typedef struct {
        bit play, nxt, prv, rdy;
        bit valid;
        int data;
        int trk;
        bit ply;
        bit care_en, en;
        int addr;
    } vec_t;

    vec_t tv [NV];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; play = 0; next_pulse = 0; prev_pulse = 0;
        word_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;
    endtask

    task automatic wait_valid(input int lim, input string nm);
        int k = 0;
        @(negedge clk);
        while (!word_valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!word_valid) chk(0, nm, 0, 1);
    endtask

    initial begin
        int k;
        tv[0]  = '{1,0,0,1, 0,0,    0,0, 1,0,0};
        tv[1]  = '{1,0,0,1, 0,0,    0,1, 1,1,0};
        tv[2]  = '{1,0,0,1, 0,0,    0,1, 1,1,1};
        tv[3]  = '{1,0,0,1, 1,0,    0,1, 1,1,2};
        tv[4]  = '{1,0,0,1, 1,1,    0,1, 1,1,3};
        tv[5]  = '{1,1,0,1, 1,2,    0,1, 0,0,0};
        tv[6]  = '{1,0,0,1, 0,0,    1,1, 1,1,1024};
        tv[7]  = '{1,0,0,1, 0,0,    1,1, 1,1,1025};
        tv[8]  = '{1,0,0,1, 1,1024, 1,1, 1,1,1026};
        tv[9]  = '{1,0,1,1, 1,1025, 1,1, 0,0,0};
        tv[10] = '{1,0,0,1, 0,0,    0,1, 1,1,0};
        tv[11] = '{1,0,1,1, 0,0,    0,1, 0,0,0};
        tv[12] = '{1,0,0,1, 0,0,    3,1, 1,1,3072};
        tv[13] = '{1,1,1,1, 0,0,    3,1, 0,0,0};
        tv[14] = '{1,0,0,1, 0,0,    0,1, 1,1,0};

        RST = 1'b0; play = 0; next_pulse = 0; prev_pulse = 0;
        word_ready = 0;
        #1;
        chk({mem_en, mem_addr, word_data, word_valid, track,
             playing, track_end} == '0, "reset_outputs",
            {mem_en, mem_addr, word_data, word_valid, track,
             playing, track_end}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;

        // Cycle-by-cycle vectors from reset.
        for (int i = 0; i < NV; i++) begin
            play = tv[i].play; next_pulse = tv[i].nxt;
            prev_pulse = tv[i].prv; word_ready = tv[i].rdy;
            @(negedge clk);
            chk(word_valid == tv[i].valid
                && (!tv[i].valid || int'(word_data) == tv[i].data)
                && int'(track) == tv[i].trk
                && playing == tv[i].ply
                && (!tv[i].care_en || (mem_en == tv[i].en
                    && (!tv[i].en || int'(mem_addr) == tv[i].addr))),
                $sformatf("vec%0d", i),
                {word_valid, word_data, track, playing, mem_en,
                 mem_addr},
                {tv[i].valid, 16'(tv[i].data), 2'(tv[i].trk),
                 tv[i].ply, tv[i].en, 12'(tv[i].addr)});
            cyc();
        end

        // Ready 1 cycle on, 3 off.
        do_reset();
        play = 1;
        for (int i = 0; i < 400; i++) begin
            word_ready = (i % 4 == 0);
            cyc();
        end
        chk(m_pop >= 95, "ready_toggle_progress", m_pop, 95);

        // Whole track consumed.
        do_reset();
        play = 1; word_ready = 1;
        k = 0;
        while (n_end == 0 && k < 1200) begin
            cyc();
            k++;
        end
        chk(n_end == 1, "track_end_seen", n_end, 1);
`ifdef MP3_AUTO_NEXT_EN
        wait_valid(10, "auto_next_timeout");
        chk(word_data == 16'd1024 && track == 2'd1, "auto_next_first",
            {track, word_data}, {2'd1, 16'd1024});
        cyc();
`else
        repeat (5) begin
            @(negedge clk);
            chk(!word_valid && !playing && track == 2'd0, "end_parked",
                {word_valid, playing, track}, 0);
            cyc();
        end
        play = 0;
        cyc();
        cyc();
        play = 1;
        wait_valid(10, "replay_timeout");
        chk(word_data == 16'd0 && track == 2'd0, "replay_first",
            {track, word_data}, 0);
        cyc();
`endif
        chk(n_end == 1, "single_end_pulse", n_end, 1);

        // Skips with a full FIFO, wraps, and simultaneous pulses.
        do_reset();
        play = 1; word_ready = 1;
        k = 0;
        while (m_pop < 96 && k < 300) begin
            cyc();
            k++;
        end
        word_ready = 0;
        repeat (6) cyc();
        @(negedge clk);
        chk(word_valid && !mem_en, "fifo_full_hold",
            {word_valid, mem_en}, 2'b10);
        cyc();
        next_pulse = 1;
        cyc();
        next_pulse = 0; word_ready = 1;
        wait_valid(10, "skip_next_timeout");
        chk(word_data == 16'd1024 && track == 2'd1, "skip_next_first",
            {track, word_data}, {2'd1, 16'd1024});
        cyc();
        prev_pulse = 1;
        cyc();
        prev_pulse = 1;
        cyc();
        prev_pulse = 0;
        wait_valid(10, "prev_wrap_timeout");
        chk(word_data == 16'd3072 && track == 2'd3, "prev_wrap_first",
            {track, word_data}, {2'd3, 16'd3072});
        cyc();
        prev_pulse = 1;
        cyc();
        prev_pulse = 0;
        @(negedge clk);
        chk(track == 2'd2, "at_track2", track, 2);
        cyc();
        next_pulse = 1; prev_pulse = 1;
        cyc();
        next_pulse = 0; prev_pulse = 0;
        @(negedge clk);
        chk(track == 2'd3, "next_wins", track, 3);
        wait_valid(10, "next_wins_timeout");
        chk(word_data == 16'd3072, "next_wins_first", word_data, 3072);
        cyc();

        // Pause with a full FIFO, then resume.
        do_reset();
        play = 1; word_ready = 1;
        k = 0;
        while (m_pop < 10 && k < 100) begin
            cyc();
            k++;
        end
        word_ready = 0;
        repeat (6) cyc();
        play = 0;
        repeat (4) begin
            @(negedge clk);
            chk(!word_valid && !mem_en && !playing, "pause_hold",
                {word_valid, mem_en, playing}, 0);
            cyc();
        end
        play = 1; word_ready = 1;
        wait_valid(5, "resume_timeout");
        chk(word_data == 16'd10, "resume_next", word_data, 10);
        cyc();

        // Asynchronous reset mid-stream.
        repeat (20) cyc();
        #2;
        RST = 1'b0;
        #1;
        chk({mem_en, mem_addr, word_data, word_valid, track,
             playing, track_end} == '0, "midstream_reset",
            {mem_en, mem_addr, word_data, word_valid, track,
             playing, track_end}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;
        repeat (10) cyc();

        // Randomized traffic.
        do_reset();
        n_pop = 0;
        for (int i = 0; i < 4000; i++) begin
            play = ($urandom_range(0, 15) != 0);
            word_ready = 1'($urandom_range(0, 1));
            next_pulse = ($urandom_range(0, 63) == 0);
            prev_pulse = ($urandom_range(0, 63) == 0);
            cyc();
        end
        next_pulse = 0; prev_pulse = 0;
        repeat (4) cyc();
        chk(n_pop > 200, "random_progress", n_pop, 200);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
